dev_timer: RTL and testbench

- Memory-mapped countdown timer on the CPU data bus.
- Services the CPU's store and load traffic (address, write data, byte enables) and returns read data.
- Drives the CPU's `interrupt` input; the peripheral end of the CPU's data and interrupt interface.
- Instantiated behind the system bridge, next to data memory.

---
 rtl/dev_timer_pkg.sv | 24 ++
 rtl/dev_timer_if.sv | 19 +
 rtl/dev_timer.sv | 137 +++++++++++++
 tb/tb_dev_timer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Contents: register offsets inside the 16-byte window, CTRL bit positions,
// MODE encodings and the FSM state type.
package timer_pkg;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;  // two bits: [2:1]
  localparam int unsigned CTRL_IM   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

endpackage

// File: rtl/dev_timer_if.sv
// CPU data-port / interrupt interface between the system bridge and the timer.
//   addr   : byte address (only the word address is decoded)
//   we     : write strobe
//   byteen : per-byte write enables, bit i covers wdata[8i+7:8i]
//   wdata  : write data
//   rdata  : read data, combinational from addr
//   irq    : interrupt request to the CPU
// master = CPU/bridge side, slave = timer side.
interface dev_timer_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, byteen, wdata, input rdata, irq);
  modport slave  (input addr, we, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/dev_timer.sv
// Memory-mapped countdown timer.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : CPU data/interrupt interface (slave side)
// Registers (offset from BASE_ADDR): 0x0 CTRL {IM, MODE[1:0], EN},
// 0x4 PRESET, 0x8 COUNT (read-only), 0xC reads 0.
// FSM: IDLE -> LOAD (COUNT <= PRESET) -> CNT (count down) -> INT
// (one-shot clears EN and returns to IDLE; auto-reload pulses the flag and
// reloads).
module dev_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input logic        clk,
  input logic        reset,
  dev_timer_if.slave bus
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic        irq_flag;
  state_t      state;
  state_t      state_nxt;

  logic        hit;
  logic [3:0]  off;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        flag_set;
  logic        flag_clr;
  logic        en_clr;
  logic        unused_addr_bits;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_addr_bits = ^bus.addr[1:0];

  always_comb begin
    hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
    off       = {bus.addr[3:2], 2'b00};
    wr        = hit && bus.we && (bus.byteen != '0);
    wr_ctrl   = wr && (off == OFF_CTRL);
    wr_preset = wr && (off == OFF_PRESET);
  end

  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:   bus.rdata = {28'd0, ctrl};
        OFF_PRESET: bus.rdata = preset;
        OFF_COUNT:  bus.rdata = count;
        default:    bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    bus.irq = irq_flag & ctrl[CTRL_IM];
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl[CTRL_EN]) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[CTRL_EN]) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // Also covers PRESET=0, so COUNT never wraps below 0.
          count_nxt = '0;
          flag_set  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl[CTRL_MODE +: 2] == MODE_RELOAD) begin
          flag_clr  = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      count <= count_nxt;
      // A CPU store to the CTRL low byte overrides the FSM's EN clear.
      if (wr_ctrl && bus.byteen[0]) ctrl <= bus.wdata[3:0];
      else if (en_clr)              ctrl[CTRL_EN] <= 1'b0;
      if (wr_preset) preset <= byte_merge(preset, bus.wdata, bus.byteen);
      // Setting the flag takes priority over any clear in the same cycle.
      if (flag_set)                                irq_flag <= 1'b1;
      else if (flag_clr || wr_ctrl || wr_preset)   irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dev_timer.sv
module tb_dev_timer;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  dev_timer_if bus();

  dev_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (timeline arithmetic) ----------------
  // n = number of rising edges since the edge that wrote EN=1 (fresh IDLE,
  // COUNT previously 0).
  function automatic int unsigned eff(input int unsigned p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic logic [31:0] exp_count(input int unsigned p, input int unsigned n,
                                            input bit reload);
    int unsigned m;
    if (n < 2) return 32'd0;
    m = n - 2;
    if (reload) m = m % (eff(p) + 2);
    return (m >= p) ? 32'd0 : (p - m);
  endfunction

  function automatic logic exp_flag(input int unsigned p, input int unsigned n,
                                    input bit reload);
    if (n < eff(p) + 2) return 1'b0;
    if (!reload) return 1'b1;
    return ((n - 2) % (eff(p) + 2)) == eff(p);
  endfunction

  function automatic logic [31:0] merge_model(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.we = 1'b0;
    bus.byteen = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.addr = a;
    bus.wdata = d;
    bus.byteen = be;
    bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    bus.byteen = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(i * 4), d);
      vectors++;
      if (d !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_reg off=%0h: got %h expected 0", i * 4, d);
      end
    end
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b expected 0", bus.irq);
    end
    // mid-count reset
    bus_write(BASE + 32'h4, 32'd100, 4'hF);
    bus_write(BASE, 32'h9, 4'hF);
    repeat (52) @(negedge clk);
    bus_read(BASE + 32'h8, d);
    vectors++;
    if (d !== 32'd50) begin
      miscompares++;
      $display("FAIL reset_precount: got %0d expected 50", d);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async_irq: got %b expected 0", bus.irq);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(BASE + 32'(i * 4), d);
      vectors++;
      if (d !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_async_reg off=%0h: got %h expected 0", i * 4, d);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus_read(BASE + 32'h8, d);
      vectors++;
      if (d !== 32'd0 || bus.irq !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle: count %0d irq %b, expected 0 and 0", d, bus.irq);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic [3:0]  cw;
    int unsigned p;
    logic        im;
    for (int it = 0; it < 5; it++) begin
      if (it == 0)      begin p = 5; im = 1'b1; end
      else if (it == 1) begin p = 4; im = 1'b0; end
      else              begin p = $urandom_range(0, 12); im = 1'($urandom_range(0, 1)); end
      do_reset();
      bus_write(BASE + 32'h4, p, 4'hF);
      cw = {im, MODE_ONESHOT, 1'b1};
      bus_write(BASE, {28'd0, cw}, 4'hF);
      for (int unsigned n = 0; n <= eff(p) + 4; n++) begin
        bus_read(BASE + 32'h8, d);
        vectors++;
        if (d !== exp_count(p, n, 1'b0)) begin
          miscompares++;
          $display("FAIL oneshot_count p=%0d n=%0d: got %0d expected %0d", p, n, d, exp_count(p, n, 1'b0));
        end
        bus_read(BASE, d);
        vectors++;
        if (d !== {28'd0, (n >= eff(p) + 3) ? (cw & 4'hE) : cw}) begin
          miscompares++;
          $display("FAIL oneshot_ctrl p=%0d n=%0d: got %h", p, n, d);
        end
        vectors++;
        if (bus.irq !== (exp_flag(p, n, 1'b0) & im)) begin
          miscompares++;
          $display("FAIL oneshot_irq p=%0d n=%0d im=%b: got %b expected %b", p, n, im, bus.irq, exp_flag(p, n, 1'b0) & im);
        end
        @(negedge clk);
      end
      bus_write(BASE, 32'h8, 4'hF);
      repeat (2) begin
        vectors++;
        if (bus.irq !== 1'b0) begin
          miscompares++;
          $display("FAIL oneshot_clear p=%0d: got %b expected 0", p, bus.irq);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reload();
    logic [31:0] d;
    int unsigned p;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 3 : $urandom_range(0, 6);
      do_reset();
      bus_write(BASE + 32'h4, p, 4'hF);
      bus_write(BASE, 32'hB, 4'hF);
      for (int unsigned n = 0; n <= 4 * (eff(p) + 2) + 3; n++) begin
        bus_read(BASE + 32'h8, d);
        vectors++;
        if (d !== exp_count(p, n, 1'b1)) begin
          miscompares++;
          $display("FAIL reload_count p=%0d n=%0d: got %0d expected %0d", p, n, d, exp_count(p, n, 1'b1));
        end
        vectors++;
        if (bus.irq !== exp_flag(p, n, 1'b1)) begin
          miscompares++;
          $display("FAIL reload_irq p=%0d n=%0d: got %b expected %b", p, n, bus.irq, exp_flag(p, n, 1'b1));
        end
        bus_read(BASE, d);
        vectors++;
        if (d !== 32'hB) begin
          miscompares++;
          $display("FAIL reload_ctrl p=%0d n=%0d: got %h expected b", p, n, d);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_byteen();
    logic [31:0] d, pre, a, data;
    logic [3:0]  ctl, be;
    int unsigned kind;
    do_reset();
    bus_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111);
    bus_write(BASE + 32'h4, 32'h1234_5678, 4'b0011);
    bus_read(BASE + 32'h4, d);
    vectors++;
    if (d !== 32'hFFFF_5678) begin
      miscompares++;
      $display("FAIL byteen_merge: got %h expected ffff5678", d);
    end
    pre = 32'hFFFF_5678;
    ctl = '0;
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 5);
      data = $urandom;
      be = 4'($urandom_range(0, 15));
      case (kind)
        0: begin bus_write(BASE + 32'h4, data, be); pre = merge_model(pre, data, be); end
        1: begin
          data[0] = 1'b0;
          bus_write(BASE, data, be);
          if (be[0]) ctl = data[3:0];
        end
        2: bus_write(BASE + 32'h8, data, be);
        3: bus_write(BASE + 32'hC, data, be);
        4: begin
          a = $urandom;
          if (a[31:4] == BASE[31:4]) a = a ^ 32'h8000_0000;
          bus_write(a, data, be);
        end
        default: bus_write(BASE + 32'h4, data, 4'b0000);
      endcase
      bus_read(BASE + 32'h4 + 32'($urandom_range(0, 3)), d);
      vectors++;
      if (d !== pre) begin
        miscompares++;
        $display("FAIL byteen_preset kind=%0d: got %h expected %h", kind, d, pre);
      end
      bus_read(BASE + 32'($urandom_range(0, 3)), d);
      vectors++;
      if (d !== {28'd0, ctl}) begin
        miscompares++;
        $display("FAIL byteen_ctrl kind=%0d: got %h expected %h", kind, d, ctl);
      end
      bus_read(BASE + 32'h8, d);
      vectors++;
      if (d !== 32'd0) begin
        miscompares++;
        $display("FAIL byteen_count kind=%0d: got %h expected 0", kind, d);
      end
      bus_read(BASE + 32'hC, d);
      vectors++;
      if (d !== 32'd0) begin
        miscompares++;
        $display("FAIL byteen_reserved kind=%0d: got %h expected 0", kind, d);
      end
      a = BASE + 32'h10 + 32'($urandom_range(0, 255));
      bus.addr = a;
      #1;
      vectors++;
      if (bus.rdata !== 32'd0) begin
        miscompares++;
        $display("FAIL byteen_miss_read addr=%h: got %h expected 0", a, bus.rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    do_reset();
    bus_write(BASE + 32'h4, 32'd10, 4'hF);
    bus_write(BASE, 32'h9, 4'hF);
    repeat (5) @(negedge clk);
    bus_read(BASE + 32'h8, d);
    vectors++;
    if (d !== 32'd7) begin
      miscompares++;
      $display("FAIL disable_pre: got %0d expected 7", d);
    end
    bus_write(BASE, 32'h8, 4'hF);
    repeat (5) begin
      bus_read(BASE + 32'h8, d);
      vectors++;
      if (d !== 32'd6 || bus.irq !== 1'b0) begin
        miscompares++;
        $display("FAIL disable_frozen: count %0d irq %b, expected 6 and 0", d, bus.irq);
      end
      @(negedge clk);
    end
    bus_write(BASE, 32'h9, 4'hF);
    for (int unsigned n = 0; n <= 13; n++) begin
      bus_read(BASE + 32'h8, d);
      vectors++;
      if (d !== ((n < 2) ? 32'd6 : exp_count(10, n, 1'b0))) begin
        miscompares++;
        $display("FAIL disable_reload n=%0d: got %0d", n, d);
      end
      vectors++;
      if (bus.irq !== exp_flag(10, n, 1'b0)) begin
        miscompares++;
        $display("FAIL disable_irq n=%0d: got %b expected %b", n, bus.irq, exp_flag(10, n, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    int unsigned p, p2;
    p  = $urandom_range(1, 8);
    p2 = $urandom_range(1, 8);
    do_reset();
    bus_write(BASE + 32'h4, p, 4'hF);
    bus_write(BASE, 32'h9, 4'hF);
    repeat (p + 1) @(negedge clk);
    // PRESET store on the edge the flag sets: the flag must still set
    bus_write(BASE + 32'h4, p2, 4'hF);
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_set_priority p=%0d: got %b expected 1", p, bus.irq);
    end
    // CTRL store on the edge the FSM clears EN: the store must win
    bus_write(BASE, 32'h9, 4'hF);
    bus_read(BASE, d);
    vectors++;
    if (d !== 32'h9) begin
      miscompares++;
      $display("FAIL simul_ctrl_wins: got %h expected 9", d);
    end
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_flag_cleared: got %b expected 0", bus.irq);
    end
    for (int unsigned n = 0; n <= eff(p2) + 3; n++) begin
      bus_read(BASE + 32'h8, d);
      vectors++;
      if (d !== exp_count(p2, n, 1'b0)) begin
        miscompares++;
        $display("FAIL simul_count p2=%0d n=%0d: got %0d expected %0d", p2, n, d, exp_count(p2, n, 1'b0));
      end
      vectors++;
      if (bus.irq !== exp_flag(p2, n, 1'b0)) begin
        miscompares++;
        $display("FAIL simul_irq p2=%0d n=%0d: got %b expected %b", p2, n, bus.irq, exp_flag(p2, n, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.addr = '0;
    bus.we = 1'b0;
    bus.byteen = '0;
    bus.wdata = '0;
    test_reset();
    test_oneshot();
    test_reload();
    test_byteen();
    test_disable();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
